pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter unit for the k6502 core family. It replaces the fixed
//   PCL/PCH select/increment path with PC load, increment and relative branch, and adds
//   a vector fetch sequencer for reset/interrupt. It models the 6502 page-crossing extra
//   cycle exactly. It sits between the control decoder and the ADL/ADH buses and drives
//   the PC onto the address path.
// PARAMETERS
//   AW         16       PC / address width in bits
//   DW         8        data width; also the branch offset and vector byte width
//   PAGE_BITS  8        low PC bits forming one page; must satisfy PAGE_BITS <= AW
//   RST_VEC    16'hFFFC address of the reset vector low byte; high byte is at RST_VEC+1
// PORTS
//   ph0         in   1      sole clock; all state updates on its rising edge
//   reset       in   1      synchronous, active-high reset
//   i_pc        in   1      increment PC by 1
//   ld_pc       in   1      load PC from ld_addr
//   ld_addr     in   AW     jump target
//   br_take     in   1      take relative branch
//   br_off      in   DW     signed two's-complement branch offset
//   vec_req     in   1      start vector fetch from vec_base (IRQ/NMI/BRK)
//   vec_base    in   AW     address of the vector low byte
//   vec_addr    out  AW     vector fetch address
//   vec_rd      out  1      vector read request
//   vec_data    in   DW     vector read data
//   vec_valid   in   1      vec_data is valid this cycle
//   pc          out  AW     current program counter
//   busy        out  1      unit is not in RUN; command inputs are ignored
//   page_cross  out  1      high during the branch high-part fix-up cycle
// BEHAVIOUR
//   Reset (ph0 edge with reset=1):
//     pc=0, state=VEC_LO, vec_addr=RST_VEC, vec_rd=1, busy=1, page_cross=0.
//     Reset asserted in any state, including mid-fetch or fix-up, aborts the operation.
//     All partial results are discarded.
//   States: VEC_LO, VEC_HI, RUN, BR_FIX.
//   VEC_LO
//     vec_rd=1, vec_addr=base.
//     On vec_valid: latch vec_data as the low byte, then go to VEC_HI with vec_addr=base+1
//     (mod 2^AW). Otherwise stay.
//   VEC_HI
//     vec_rd=1.
//     On vec_valid: pc = {vec_data, low byte}, then go to RUN. The vector is DW*2 bits;
//     the upper bits are truncated or zero-padded to AW.
//   RUN
//     busy=0, vec_rd=0. Priority per cycle: vec_req > ld_pc > br_take > i_pc.
//     vec_req: latch vec_base, go to VEC_LO. pc is unchanged until the fetch completes.
//     ld_pc: pc=ld_addr next cycle.
//     br_take: target = pc + sext(br_off), mod 2^AW.
//       If target[AW-1:PAGE_BITS] == pc[AW-1:PAGE_BITS], pc=target in 1 cycle; stay in RUN.
//       Otherwise the low PAGE_BITS of pc update first (the high part is kept), then go to
//       BR_FIX.
//     i_pc: pc=pc+1, wrapping from all-ones to 0.
//     No command: pc holds.
//   BR_FIX
//     busy=1, page_cross=1.
//     The high part of pc takes target's high part, then go to RUN. Total branch
//     latency is 2 cycles.
//   Inputs while busy=1 are ignored and are not queued.
//   vec_rd stays asserted until vec_valid; vec_valid while vec_rd=0 is ignored.
//   Outputs are registered; pc reflects a command one cycle after it is sampled.
// TESTING
//   1 Reset, then vec_valid with data 34h then 12h -> pc=1234h, busy=0 after 3rd edge;
//     vec_addr = FFFCh then FFFDh.
//   2 pc=1234h, i_pc held 3 cycles -> pc=1237h; pc=FFFFh, i_pc -> pc=0000h.
//   3 pc=1234h, br_take, br_off=10h -> pc=1244h next cycle, page_cross never set.
//   4 pc=12F0h, br_take, br_off=20h -> pc=1210h, then 1310h with page_cross=1;
//     i_pc during BR_FIX is ignored.
//   5 pc=1205h, br_take, br_off=F0h (-16) -> pc=12F5h, then 11F5h.
//   6 vec_req with ld_pc and i_pc in the same cycle, vec_base=FFFEh -> vector fetch wins.
//     Reset asserted mid-VEC_HI -> restarts at FFFCh with pc=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Command/vector bus between the control decoder and the program-counter unit.
// The master drives commands and vector read data; the slave returns pc and status.
interface pc_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          i_pc;
    logic          ld_pc;
    logic [AW-1:0] ld_addr;
    logic          br_take;
    logic [DW-1:0] br_off;
    logic          vec_req;
    logic [AW-1:0] vec_base;
    logic [AW-1:0] vec_addr;
    logic          vec_rd;
    logic [DW-1:0] vec_data;
    logic          vec_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          page_cross;

    modport master (
        output i_pc, ld_pc, ld_addr, br_take, br_off, vec_req, vec_base,
               vec_data, vec_valid,
        input  vec_addr, vec_rd, pc, busy, page_cross
    );

    modport slave (
        input  i_pc, ld_pc, ld_addr, br_take, br_off, vec_req, vec_base,
               vec_data, vec_valid,
        output vec_addr, vec_rd, pc, busy, page_cross
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with load/increment/relative branch, 6502-style page-crossing
// fix-up cycle, and a two-byte vector fetch sequencer for reset and interrupts.
module pc_sequencer #(
    parameter int            AW        = 16,
    parameter int            DW        = 8,
    parameter int            PAGE_BITS = 8,
    parameter logic [AW-1:0] RST_VEC   = AW'(16'hFFFC)
) (
    input logic           ph0,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] ST_VEC_LO = 2'd0;
    localparam logic [1:0] ST_VEC_HI = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_BR_FIX = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [AW-1:0] base_reg, base_next;
    logic [AW-1:0] vec_addr_reg, vec_addr_next;
    logic [DW-1:0] lo_reg, lo_next;
    logic [AW-1:0] tgt_reg, tgt_next;

    logic [2*DW-1:0] vec_word;
    logic [AW-1:0]   vec_pc;
    logic [AW-1:0]   off_ext;
    logic [AW-1:0]   lo_mask;
    logic [AW-1:0]   target;
    logic            same_page;

    assign vec_word = {bus.vec_data, lo_reg};

    // Per-bit resize of the vector word, sign extension of the offset, and the page mask.
    for (genvar gi = 0; gi < AW; gi++) begin : g_bits
        if (gi < 2*DW) begin : g_vec
            assign vec_pc[gi] = vec_word[gi];
        end else begin : g_vec_pad
            assign vec_pc[gi] = 1'b0;
        end
        if (gi < DW) begin : g_off
            assign off_ext[gi] = bus.br_off[gi];
        end else begin : g_off_sign
            assign off_ext[gi] = bus.br_off[DW-1];
        end
        assign lo_mask[gi] = (gi < PAGE_BITS);
    end

    assign target    = pc_reg + off_ext;
    assign same_page = ((target ^ pc_reg) & ~lo_mask) == '0;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        base_next     = base_reg;
        vec_addr_next = vec_addr_reg;
        lo_next       = lo_reg;
        tgt_next      = tgt_reg;
        case (state_reg)
            ST_VEC_LO: begin
                if (bus.vec_valid) begin
                    lo_next       = bus.vec_data;
                    vec_addr_next = base_reg + 1'b1;
                    state_next    = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                if (bus.vec_valid) begin
                    pc_next    = vec_pc;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.vec_req) begin
                    base_next     = bus.vec_base;
                    vec_addr_next = bus.vec_base;
                    state_next    = ST_VEC_LO;
                end else if (bus.ld_pc) begin
                    pc_next = bus.ld_addr;
                end else if (bus.br_take) begin
                    if (same_page) begin
                        pc_next = target;
                    end else begin
                        // Low page bits move now; the high part follows in the fix-up cycle.
                        pc_next    = (pc_reg & ~lo_mask) | (target & lo_mask);
                        tgt_next   = target;
                        state_next = ST_BR_FIX;
                    end
                end else if (bus.i_pc) begin
                    pc_next = pc_reg + 1'b1;
                end
            end
            default: begin
                pc_next    = (tgt_reg & ~lo_mask) | (pc_reg & lo_mask);
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge ph0) begin
        if (reset) begin
            state_reg    <= ST_VEC_LO;
            pc_reg       <= '0;
            base_reg     <= RST_VEC;
            vec_addr_reg <= RST_VEC;
            lo_reg       <= '0;
            tgt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            base_reg     <= base_next;
            vec_addr_reg <= vec_addr_next;
            lo_reg       <= lo_next;
            tgt_reg      <= tgt_next;
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.vec_addr   = vec_addr_reg;
    assign bus.vec_rd     = (state_reg == ST_VEC_LO) || (state_reg == ST_VEC_HI);
    assign bus.busy       = (state_reg != ST_RUN);
    assign bus.page_cross = (state_reg == ST_BR_FIX);
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer; a reference model pushes the
// expected post-edge outputs into a queue that a separate monitor drains.
module tb_pc_sequencer;
    localparam int AW = 16;
    localparam int DW = 8;

    logic ph0 = 1'b0;
    logic reset;

    pc_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    pc_sequencer #(
        .AW(AW), .DW(DW), .PAGE_BITS(8), .RST_VEC(16'hFFFC)
    ) dut (
        .ph0(ph0),
        .reset(reset),
        .bus(bus)
    );

    always #5 ph0 = ~ph0;

    typedef struct {
        logic [15:0] pc;
        logic        busy;
        logic        page_cross;
        logic        vec_rd;
        logic [15:0] vec_addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pc, an in-progress vector fetch (bytes done so far),
    // and a list of pc values still owed by an unfinished page-crossing branch.
    int m_pc;
    bit m_fetch;
    int m_step;
    int m_base;
    int m_lo;
    int m_pend[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge();
        int tgt;
        int off;
        if (reset) begin
            m_pc = 0; m_fetch = 1; m_step = 0; m_base = 16'hFFFC;
            m_pend.delete();
        end else if (m_pend.size() > 0) begin
            m_pc = m_pend.pop_front();
        end else if (m_fetch) begin
            if (bus.vec_valid) begin
                if (m_step == 0) begin
                    m_lo = int'(bus.vec_data);
                    m_step = 1;
                end else begin
                    m_pc = ((int'(bus.vec_data) << 8) | m_lo) & 16'hFFFF;
                    m_fetch = 0;
                end
            end
        end else if (bus.vec_req) begin
            m_fetch = 1; m_step = 0; m_base = int'(bus.vec_base);
        end else if (bus.ld_pc) begin
            m_pc = int'(bus.ld_addr);
        end else if (bus.br_take) begin
            off = int'(bus.br_off);
            if (off > 127) off -= 256;
            tgt = (m_pc + off) & 16'hFFFF;
            if ((tgt >> 8) == (m_pc >> 8)) begin
                m_pc = tgt;
            end else begin
                m_pc = (m_pc & 16'hFF00) | (tgt & 16'h00FF);
                m_pend.push_back(tgt);
            end
        end else if (bus.i_pc) begin
            m_pc = (m_pc + 1) & 16'hFFFF;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge ph0);
        model_edge();
        e.pc         = m_pc[15:0];
        e.busy       = m_fetch || (m_pend.size() > 0);
        e.page_cross = (m_pend.size() > 0);
        e.vec_rd     = m_fetch;
        e.vec_addr   = 16'((m_base + m_step) & 16'hFFFF);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic idle();
        bus.i_pc = 0; bus.ld_pc = 0; bus.br_take = 0; bus.vec_req = 0; bus.vec_valid = 0;
    endtask

    task automatic load(input logic [15:0] a);
        idle(); bus.ld_pc = 1; bus.ld_addr = a; tick(); idle();
    endtask

    // Monitor: compares DUT outputs against every expectation pushed at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge ph0);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("busy", 16'(bus.busy), 16'(e.busy));
                check("page_cross", 16'(bus.page_cross), 16'(e.page_cross));
                check("vec_rd", 16'(bus.vec_rd), 16'(e.vec_rd));
                if (e.vec_rd) check("vec_addr", bus.vec_addr, e.vec_addr);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; idle();
        bus.ld_addr = '0; bus.br_off = '0; bus.vec_base = '0; bus.vec_data = '0;
        m_pc = 0; m_fetch = 1; m_step = 0; m_base = 16'hFFFC; m_lo = 0;
        #2;

        // Reset vector fetch
        tick(); reset = 0;
        check("t1_rst_pc", bus.pc, 16'h0000);
        check("t1_vec_addr_lo", bus.vec_addr, 16'hFFFC);
        bus.vec_valid = 1; bus.vec_data = 8'h34; tick();
        check("t1_vec_addr_hi", bus.vec_addr, 16'hFFFD);
        bus.vec_data = 8'h12; tick(); idle();
        check("t1_pc", bus.pc, 16'h1234);
        check("t1_busy", 16'(bus.busy), 16'h0);

        // Increment and wrap
        bus.i_pc = 1; tick(); tick(); tick(); idle();
        check("t2_inc", bus.pc, 16'h1237);
        load(16'hFFFF);
        bus.i_pc = 1; tick(); idle();
        check("t2_wrap", bus.pc, 16'h0000);

        // Branch within page
        load(16'h1234);
        bus.br_take = 1; bus.br_off = 8'h10; tick(); idle();
        check("t3_pc", bus.pc, 16'h1244);
        check("t3_pcross", 16'(bus.page_cross), 16'h0);

        // Forward page cross, i_pc ignored during fix-up
        load(16'h12F0);
        bus.br_take = 1; bus.br_off = 8'h20; tick(); idle();
        check("t4_lo", bus.pc, 16'h1210);
        check("t4_pcross", 16'(bus.page_cross), 16'h1);
        bus.i_pc = 1; tick(); idle();
        check("t4_hi", bus.pc, 16'h1310);
        check("t4_pcross_clr", 16'(bus.page_cross), 16'h0);

        // Backward page cross
        load(16'h1205);
        bus.br_take = 1; bus.br_off = 8'hF0; tick(); idle();
        check("t5_lo", bus.pc, 16'h12F5);
        tick();
        check("t5_hi", bus.pc, 16'h11F5);

        // vec_req priority, then reset mid-VEC_HI
        bus.vec_req = 1; bus.ld_pc = 1; bus.i_pc = 1; bus.ld_addr = 16'h4000;
        bus.vec_base = 16'hFFFE; tick(); idle();
        check("t6_busy", 16'(bus.busy), 16'h1);
        check("t6_vec_addr", bus.vec_addr, 16'hFFFE);
        check("t6_pc_hold", bus.pc, 16'h11F5);
        bus.vec_valid = 1; bus.vec_data = 8'h78; tick(); idle();
        check("t6_vec_addr_hi", bus.vec_addr, 16'hFFFF);
        reset = 1; tick(); reset = 0;
        check("t6_rst_addr", bus.vec_addr, 16'hFFFC);
        check("t6_rst_pc", bus.pc, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 149) == 0);
            bus.vec_req   = ($urandom_range(0, 19) == 0);
            bus.ld_pc     = ($urandom_range(0, 5) == 0);
            bus.br_take   = ($urandom_range(0, 2) == 0);
            bus.i_pc      = $urandom_range(0, 1) == 1;
            bus.vec_valid = $urandom_range(0, 1) == 1;
            bus.ld_addr   = 16'($urandom);
            bus.br_off    = 8'($urandom);
            bus.vec_base  = 16'($urandom);
            bus.vec_data  = 8'($urandom);
            tick();
        end
        reset = 0; idle();
        tick();
        #5;
        check("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
